// File: rtl/adc_ctrl_pkg.sv
// Shared definitions for the ADC stream controller: state encodings,
// default sample width and the counter width helper.
package adc_ctrl_pkg;

    localparam int DATA_W_DEF = 10;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_WARMUP  = 3'd1;
    localparam state_t ST_CALIB   = 3'd2;
    localparam state_t ST_RUN     = 3'd3;
    localparam state_t ST_HOLDOFF = 3'd4;

    // Ceiling log2; a counter holding values 0..N needs clog2(N+1) bits.
    function automatic int clog2(input int value);
        int bits_v;
        int rem_v;
        bits_v = 0;
        rem_v  = value - 1;
        while (rem_v > 0) begin
            bits_v = bits_v + 1;
            rem_v  = rem_v >> 1;
        end
        return bits_v;
    endfunction

endpackage

// File: rtl/adc_dc_estimator.sv
// DC-offset estimator: averages 2^CAL_LOG2 clean valid samples and
// publishes the floored mean together with a one-cycle done strobe.
module adc_dc_estimator
    import adc_ctrl_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int CAL_LOG2 = 10
) (
    input  logic              clk_adc,
    input  logic              rst,
    input  logic              clear,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    input  logic              sample_ovr,
    output logic [DATA_W-1:0] offset,
    output logic              done,
    output logic              last
);
    localparam int ACC_W = DATA_W + CAL_LOG2;
    localparam int CNT_W = clog2((1 << CAL_LOG2) + 1);

    logic [ACC_W-1:0]  acc_r;
    logic [ACC_W-1:0]  acc_sum_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [DATA_W-1:0] offset_r;
    logic              done_r;
    logic              take_s;

    // Sample acceptance, running sum and completion detect
    always_comb begin
        take_s    = ~clear & sample_valid & ~sample_ovr;
        acc_sum_s = acc_r + {{CAL_LOG2{sample_in[DATA_W-1]}}, sample_in};
        last      = take_s & (cnt_r == CNT_W'((1 << CAL_LOG2) - 1));
    end

    // Accumulator and sample counter; restart on clear or on completion
    always_ff @(posedge clk_adc or posedge rst) begin
        if (rst) begin
            acc_r <= '0;
            cnt_r <= '0;
        end else if (clear || last) begin
            acc_r <= '0;
            cnt_r <= '0;
        end else if (take_s) begin
            acc_r <= acc_sum_s;
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    // Offset register; the upper slice of the sum is the floored arithmetic shift
    always_ff @(posedge clk_adc or posedge rst) begin
        if (rst) begin
            offset_r <= '0;
            done_r   <= 1'b0;
        end else begin
            done_r <= last;
            if (last) begin
                offset_r <= acc_sum_s[ACC_W-1:CAL_LOG2];
            end
        end
    end

    assign offset = offset_r;
    assign done   = done_r;

endmodule

// File: rtl/adc_stream_controller.sv
// ADC stream sequencer: warm-up, DC calibration, offset-corrected streaming
// and overload hold-off with automatic recalibration.
module adc_stream_controller
    import adc_ctrl_pkg::*;
#(
    parameter int DATA_W         = DATA_W_DEF,
    parameter int CAL_LOG2       = 10,
    parameter int WARMUP_CYCLES  = 64,
    parameter int OVR_THRESH     = 8,
    parameter int HOLDOFF_CYCLES = 256
) (
    input  logic              clk_adc,
    input  logic              rst,
    input  logic              enable,
    input  logic              recal_req,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_in_valid,
    input  logic              sample_ovr,
    output logic [DATA_W:0]   sample_out,
    output logic              sample_out_valid,
    output logic [DATA_W-1:0] dc_offset,
    output logic              cal_done,
    output logic              overload,
    output logic [15:0]       overload_count,
    output logic [2:0]        state
);
    localparam int WARM_W = clog2(WARMUP_CYCLES + 1);
    localparam int OVR_W  = clog2(OVR_THRESH + 1);
    localparam int HOLD_W = clog2(HOLDOFF_CYCLES + 1);

    state_t            state_r;
    state_t            state_nxt_s;
    logic [WARM_W-1:0] warm_cnt_r;
    logic [OVR_W-1:0]  ovr_cnt_r;
    logic [HOLD_W-1:0] hold_cnt_r;
    logic [15:0]       ovl_cnt_r;
    logic [DATA_W:0]   out_r;
    logic [DATA_W:0]   out_nxt_s;
    logic              out_vld_r;
    logic              out_vld_nxt_s;
    logic              overload_r;
    logic              est_clear_s;
    logic              est_last_s;
    logic              est_done_s;
    logic [DATA_W-1:0] dc_offset_s;
    logic              warm_done_s;
    logic              ovr_trig_s;
    logic              hold_done_s;

    adc_dc_estimator #(
        .DATA_W   (DATA_W),
        .CAL_LOG2 (CAL_LOG2)
    ) u_dc_est (
        .clk_adc      (clk_adc),
        .rst          (rst),
        .clear        (est_clear_s),
        .sample_in    (sample_in),
        .sample_valid (sample_in_valid),
        .sample_ovr   (sample_ovr),
        .offset       (dc_offset_s),
        .done         (est_done_s),
        .last         (est_last_s)
    );

    // Phase-completion and trigger conditions
    always_comb begin
        est_clear_s = ~enable | recal_req | (state_r != ST_CALIB);
        warm_done_s = (warm_cnt_r == WARM_W'(WARMUP_CYCLES - 1));
        ovr_trig_s  = enable & (state_r == ST_RUN) & sample_in_valid & sample_ovr &
                      (ovr_cnt_r == OVR_W'(OVR_THRESH - 1));
        hold_done_s = ~sample_ovr & (hold_cnt_r == HOLD_W'(HOLDOFF_CYCLES - 1));
    end

    // State register
    always_ff @(posedge clk_adc or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; enable low overrides everything
    always_comb begin
        state_nxt_s = ST_IDLE;
        if (!enable) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE:    state_nxt_s = ST_WARMUP;
                ST_WARMUP:  state_nxt_s = warm_done_s ? ST_CALIB : ST_WARMUP;
                ST_CALIB:   state_nxt_s = est_last_s ? ST_RUN : ST_CALIB;
                ST_RUN: begin
                    if (ovr_trig_s) begin
                        state_nxt_s = ST_HOLDOFF;
                    end else if (recal_req) begin
                        state_nxt_s = ST_CALIB;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                ST_HOLDOFF: state_nxt_s = hold_done_s ? ST_CALIB : ST_HOLDOFF;
                default:    state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // Phase counters and the saturating overload event counter
    always_ff @(posedge clk_adc or posedge rst) begin
        if (rst) begin
            warm_cnt_r <= '0;
            ovr_cnt_r  <= '0;
            hold_cnt_r <= '0;
            ovl_cnt_r  <= 16'h0000;
        end else begin
            if (state_r == ST_WARMUP && state_nxt_s == ST_WARMUP) begin
                warm_cnt_r <= warm_cnt_r + WARM_W'(1);
            end else begin
                warm_cnt_r <= '0;
            end
            if (state_r != ST_RUN || state_nxt_s != ST_RUN) begin
                ovr_cnt_r <= '0;
            end else if (sample_in_valid) begin
                ovr_cnt_r <= sample_ovr ? ovr_cnt_r + OVR_W'(1) : '0;
            end
            if (state_r == ST_HOLDOFF && state_nxt_s == ST_HOLDOFF) begin
                hold_cnt_r <= sample_ovr ? '0 : hold_cnt_r + HOLD_W'(1);
            end else begin
                hold_cnt_r <= '0;
            end
            if (ovr_trig_s && ovl_cnt_r != 16'hFFFF) begin
                ovl_cnt_r <= ovl_cnt_r + 16'd1;
            end
        end
    end

    // Corrected-sample datapath; the overload-triggering sample is dropped
    always_comb begin
        out_vld_nxt_s = (state_r == ST_RUN) & sample_in_valid & ~ovr_trig_s;
        if (out_vld_nxt_s) begin
            out_nxt_s = {sample_in[DATA_W-1], sample_in} - {dc_offset_s[DATA_W-1], dc_offset_s};
        end else begin
            out_nxt_s = out_r;
        end
    end

    // Output registers
    always_ff @(posedge clk_adc or posedge rst) begin
        if (rst) begin
            out_r      <= '0;
            out_vld_r  <= 1'b0;
            overload_r <= 1'b0;
        end else begin
            out_r      <= out_nxt_s;
            out_vld_r  <= out_vld_nxt_s;
            overload_r <= (state_nxt_s == ST_HOLDOFF);
        end
    end

    assign sample_out       = out_r;
    assign sample_out_valid = out_vld_r;
    assign dc_offset        = dc_offset_s;
    assign cal_done         = est_done_s;
    assign overload         = overload_r;
    assign overload_count   = ovl_cnt_r;
    assign state            = state_r;

endmodule

// File: doc/adc_stream_controller.md
# adc_stream_controller

Sequences the ADC sample stream between the ADC front-end registers and the DDC/processing chain: start-up warm-up, DC-offset calibration, corrected streaming, and overload hold-off with automatic recalibration. It owns the DC-offset estimate and gates sample validity downstream, so no uncalibrated or overloaded samples reach the processing domain. It runs entirely in the 105 MHz ADC clock domain.

## Interface
- DATA_W, 10, ADC sample width (two's complement)
- CAL_LOG2, 10, log2 of the number of valid samples averaged per calibration (1024)
- WARMUP_CYCLES, 64, clock cycles spent in WARMUP after enable
- OVR_THRESH, 8, consecutive overflowed valid samples that trigger overload
- HOLDOFF_CYCLES, 256, overflow-free clock cycles required to leave HOLDOFF

Ports:
- clk_adc  in  1  ADC clock, single clock domain
- rst  in  1  asynchronous, active-high reset
- enable  in  1  level; 1 = run the sequence, 0 = return to IDLE
- recal_req  in  1  single-cycle pulse requesting a new calibration
- sample_in  in  DATA_W  signed ADC sample
- sample_in_valid  in  1  sample_in qualifier
- sample_ovr  in  1  ADC overflow flag aligned with sample_in
- sample_out  out  DATA_W+1  signed, offset-corrected sample
- sample_out_valid  out  1  sample_out qualifier
- dc_offset  out  DATA_W  current signed offset estimate
- cal_done  out  1  one-cycle pulse when a calibration completes
- overload  out  1  high while in HOLDOFF
- overload_count  out  16  number of overload events, saturating at 0xFFFF
- state  out  3  current state encoding

## Operation
- States: IDLE=0, WARMUP=1, CALIB=2, RUN=3, HOLDOFF=4. Encodings 5–7 are unused and return to IDLE.
- If enable=0, any state goes to IDLE on the next clock. This has top priority. Accumulator and counters clear; dc_offset and overload_count are retained.
- IDLE→WARMUP when enable=1.
- WARMUP: a cycle counter runs. After WARMUP_CYCLES cycles, go to CALIB.
- CALIB: for each valid sample with sample_ovr=0:
  - accumulate the sign-extended sample into a DATA_W+CAL_LOG2 signed accumulator;
  - increment the sample count.
- CALIB, overflowed valid samples are skipped: not accumulated and not counted.
- CALIB, when the count reaches 2^CAL_LOG2:
  - dc_offset ← acc >>> CAL_LOG2 (arithmetic shift, floor);
  - cal_done pulses;
  - go to RUN.
- recal_req during CALIB clears the accumulator and count and restarts averaging. It is ignored in IDLE, WARMUP and HOLDOFF.
- RUN:
  - each valid input gives sample_out = sext(sample_in) − sext(dc_offset), width DATA_W+1, so the result never overflows;
  - sample_out_valid=1.
- RUN, overflow tracking: a consecutive-overflow counter increments on each valid sample with sample_ovr=1 and clears on each valid sample with sample_ovr=0. Invalid cycles leave it unchanged.
- RUN, when the counter reaches OVR_THRESH:
  - go to HOLDOFF;
  - overload_count increments (saturating);
  - the triggering sample is not output.
- RUN, recal_req goes to CALIB. If recal_req and the overload trigger occur in the same cycle, HOLDOFF wins.
- HOLDOFF: sample_out_valid=0. A cycle counter resets on any cycle with sample_ovr=1 (valid or not). After HOLDOFF_CYCLES consecutive clean cycles, go to CALIB.

## Timing
- Reset values:
  - state=IDLE;
  - sample_out=0, sample_out_valid=0;
  - dc_offset=0;
  - cal_done=0;
  - overload=0;
  - overload_count=0;
  - all counters and the accumulator 0.
- All outputs are registered.
- sample_out/sample_out_valid: 1-cycle latency from the sample_in/sample_in_valid cycle in RUN. The last sample accepted in RUN is still output on the cycle after a transition out of RUN, except the overload-triggering sample.
- cal_done and the new dc_offset are visible in the same cycle that state first reads RUN. The first corrected sample can be output the cycle after that.
- overload rises in the cycle state reads HOLDOFF and falls in the cycle state reads CALIB.
- The sample completing calibration is the last one accumulated. It is not output.
- Reset asserted mid-operation clears everything immediately. Deassertion resumes at IDLE.

## Structure
- Package adc_ctrl_pkg holds:
  - state encodings as localparams/typedef;
  - the shared DATA_W default;
  - the counter width derivation function (clog2).
- Sub-module adc_dc_estimator: accumulator, sample counter, shift, and done strobe, with clear/restart inputs. The FSM, overflow tracking, hold-off and output correction stay in the top.

## Test plan
- Reset then enable=1, constant valid sample_in=+5, no ovr → state WARMUP for 64 cycles, CALIB for 1024 samples; then cal_done=1, dc_offset=5, state=RUN; next sample gives sample_out=0.
- Calibrate with alternating −3/−4 → dc_offset=−4 (floor of −3.5). Input +511 in RUN → sample_out=+515 with no wrap.
- In RUN, 7 ovr samples, 1 clean sample, 8 ovr samples → overload only after the 8th consecutive ovr; overload_count=1; no output for the triggering sample.
- In HOLDOFF, inject ovr at clean-cycle 200 → exit after 256 further clean cycles to CALIB, then cal_done and RUN.
- recal_req and the 8th consecutive ovr in the same cycle → HOLDOFF, not CALIB. recal_req at calibration sample 500 → count restarts; cal_done 1024 samples later.
- enable=0 mid-CALIB → IDLE next cycle, dc_offset holds its previous value. Reset mid-RUN → all outputs 0 asynchronously.
